// File: rtl/experiment_fsm.sv
// Single-shot sequencer: arm on start, align to fast gate, fire detonator,
// confirm by debounced wire break, then fire the detector trigger.
module experiment_fsm #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned DET_DELAY_CYC    = 360000,
    parameter int unsigned DET_PULSE_CYC    = 2000,
    parameter int unsigned DEBOUNCE_CYC     = 400,
    parameter int unsigned WIRE_TIMEOUT_CYC = 400000,
    parameter int unsigned TRIG_PULSE_CYC   = 200,
    parameter int unsigned COUNTER_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_signal,
    input  logic                     fg_signal,
    input  logic                     wire_signal,
    input  logic                     detector_ready,
    output logic                     detonation_signal,
    output logic                     output_trigger,
    output logic [2:0]               scenario_state,
    output logic [COUNTER_WIDTH-1:0] counter_
);

    localparam int unsigned NUM_IN    = 4;
    localparam int unsigned IDX_START = 0;
    localparam int unsigned IDX_FG    = 1;
    localparam int unsigned IDX_WIRE  = 2;
    localparam int unsigned IDX_READY = 3;
    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_DELAY    = 3'd2,
        S_DETONATE = 3'd3,
        S_WIRE_OK  = 3'd4,
        S_TRIGGER  = 3'd5,
        S_WAIT_DET = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    logic [NUM_IN-1:0] async_in;
    logic [NUM_IN-1:0] sync_ff [SYNC_STAGES];
    logic [NUM_IN-1:0] sync_v;
    logic              start_d;
    logic              fg_d;
    logic              start_rise;
    logic              fg_rise;

    state_t                   state;
    state_t                   state_n;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] cnt_n;
    logic [COUNTER_WIDTH-1:0] cnt_inc;
    logic [DEB_W-1:0]         stab;
    logic [DEB_W-1:0]         stab_n;
    logic                     wire_valid;
    logic                     seen_low;
    logic                     seen_low_n;
    logic                     det_q;
    logic                     det_n;
    logic                     trig_q;
    logic                     trig_n;

    assign async_in = {detector_ready, wire_signal, fg_signal, start_signal};
    assign sync_v   = sync_ff[SYNC_STAGES-1];

    // Multi-flop synchronizers plus one-cycle history for rising-edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
            start_d <= 1'b0;
            fg_d    <= 1'b0;
        end else begin
            sync_ff[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
            start_d <= sync_v[IDX_START];
            fg_d    <= sync_v[IDX_FG];
        end
    end

    assign start_rise = sync_v[IDX_START] & ~start_d;
    assign fg_rise    = sync_v[IDX_FG] & ~fg_d;
    assign cnt_inc    = (&cnt) ? cnt : cnt + COUNTER_WIDTH'(1);
    assign wire_valid = (stab >= DEB_W'(DEBOUNCE_CYC));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            stab     <= '0;
            seen_low <= 1'b0;
            det_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            stab     <= stab_n;
            seen_low <= seen_low_n;
            det_q    <= det_n;
            trig_q   <= trig_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        stab_n     = '0;
        seen_low_n = 1'b0;
        det_n      = 1'b0;
        trig_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_rise && sync_v[IDX_READY]) state_n = S_ARMED;
            end
            S_ARMED: begin
                if (fg_rise) state_n = S_DELAY;
            end
            S_DELAY: begin
                if (cnt >= COUNTER_WIDTH'(DET_DELAY_CYC - 1)) state_n = S_DETONATE;
            end
            S_DETONATE: begin
                // A valid wire wins over a timeout landing in the same cycle
                if (wire_valid) begin
                    state_n = S_WIRE_OK;
                end else if (cnt >= COUNTER_WIDTH'(WIRE_TIMEOUT_CYC)) begin
                    state_n = S_ERROR;
                end
            end
            S_WIRE_OK: begin
                state_n = sync_v[IDX_READY] ? S_TRIGGER : S_ERROR;
            end
            S_TRIGGER: begin
                if (cnt >= COUNTER_WIDTH'(TRIG_PULSE_CYC - 1)) state_n = S_WAIT_DET;
            end
            S_WAIT_DET: begin
                if (seen_low && sync_v[IDX_READY]) state_n = S_IDLE;
            end
            S_ERROR: begin
                if (!sync_v[IDX_START] && sync_v[IDX_READY]) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        cnt_n = (state_n != state) ? '0 : cnt_inc;

        if (state == S_DETONATE && sync_v[IDX_WIRE]) begin
            stab_n = (stab >= DEB_W'(DEBOUNCE_CYC)) ? stab : stab + DEB_W'(1);
        end

        // A low phase already in progress on entry to WAIT_DET counts
        seen_low_n = (state == S_WAIT_DET) && (seen_low || !sync_v[IDX_READY]);

        det_n  = (state_n == S_DETONATE) && (cnt_n < COUNTER_WIDTH'(DET_PULSE_CYC));
        trig_n = (state_n == S_TRIGGER);
    end

    assign detonation_signal = det_q;
    assign output_trigger    = trig_q;
    assign scenario_state    = state;
    assign counter_          = cnt;

endmodule

// File: tb/tb_experiment_fsm.sv
// Scoreboard bench for experiment_fsm with shortened timing parameters;
// a negedge monitor checks state sequence, state durations and pulse widths.
module tb_experiment_fsm;

    localparam int unsigned CW        = 32;
    localparam int          DET_DELAY = 300;
    localparam int          DET_PULSE = 60;
    localparam int          DEBOUNCE  = 20;
    localparam int          TIMEOUT   = 200;
    localparam int          TRIG      = 10;

    logic          clock;
    logic          reset;
    logic          start_signal;
    logic          fg_signal;
    logic          wire_signal;
    logic          detector_ready;
    logic          detonation_signal;
    logic          output_trigger;
    logic [2:0]    scenario_state;
    logic [CW-1:0] counter_;

    experiment_fsm #(
        .SYNC_STAGES      (2),
        .DET_DELAY_CYC    (DET_DELAY),
        .DET_PULSE_CYC    (DET_PULSE),
        .DEBOUNCE_CYC     (DEBOUNCE),
        .WIRE_TIMEOUT_CYC (TIMEOUT),
        .TRIG_PULSE_CYC   (TRIG),
        .COUNTER_WIDTH    (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start_signal      (start_signal),
        .fg_signal         (fg_signal),
        .wire_signal       (wire_signal),
        .detector_ready    (detector_ready),
        .detonation_signal (detonation_signal),
        .output_trigger    (output_trigger),
        .scenario_state    (scenario_state),
        .counter_          (counter_)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed { int state; int dur; } st_exp_t;
    typedef struct packed { int kind; int width; } pl_exp_t;

    st_exp_t st_q[$];
    pl_exp_t pl_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    int mon_prev = 0;
    int mon_dur  = 0;
    int det_w    = 0;
    int trig_w   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_state(input int s, input int d);
        st_q.push_back('{state: s, dur: d});
    endtask

    task automatic exp_pulse(input int k, input int w);
        pl_q.push_back('{kind: k, width: w});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_state(input int code, input int budget, output int cyc);
        cyc = 0;
        while (int'(scenario_state) != code && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check("wait_state", int'(scenario_state), code);
    endtask

    task automatic report_pulse(input int kind, input int width);
        pl_exp_t e;
        if (pl_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: kind %0d width %0d, expected none", kind, width);
        end else begin
            e = pl_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_width", width, e.width);
        end
    endtask

    // Monitor: compares every state change and completed pulse against the queues
    always @(negedge clock) begin
        st_exp_t e;
        if (!reset) begin
            mon_prev = 0;
            mon_dur  = 0;
            det_w    = 0;
            trig_w   = 0;
        end else begin
            if (int'(scenario_state) != mon_prev) begin
                if (st_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_state: got %0d from %0d, expected none",
                             scenario_state, mon_prev);
                end else begin
                    e = st_q.pop_front();
                    check("state_seq", int'(scenario_state), e.state);
                    if (e.dur >= 0) check("state_dur", mon_dur, e.dur);
                end
                check("counter_on_entry", int'(counter_), 0);
                mon_prev = int'(scenario_state);
                mon_dur  = 1;
            end else begin
                mon_dur++;
            end
            if (detonation_signal) det_w++;
            else if (det_w > 0) begin
                report_pulse(0, det_w);
                det_w = 0;
            end
            if (output_trigger) trig_w++;
            else if (trig_w > 0) begin
                report_pulse(1, trig_w);
                trig_w = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int hi_len [10] = '{3, 5, 2, 12, 4, 15, 2, 6, 10, 4};
    int lo_len [10] = '{2, 4, 8, 3, 2, 5, 7, 2, 9, 3};

    initial begin
        int c;
        reset          = 1'b0;
        start_signal   = 1'b0;
        fg_signal      = 1'b0;
        wire_signal    = 1'b0;
        detector_ready = 1'b1;
        tick(10);
        check("rst_state", int'(scenario_state), 0);
        check("rst_counter", int'(counter_), 0);
        check("rst_det", int'(detonation_signal), 0);
        check("rst_trig", int'(output_trigger), 0);
        reset = 1'b1;
        tick(5);

        // Normal shot with bouncy wire and detector handshake
        exp_state(1, -1); exp_state(2, -1); exp_state(3, DET_DELAY);
        exp_state(4, -1); exp_state(5, 1);  exp_state(6, TRIG); exp_state(0, -1);
        exp_pulse(0, DET_PULSE); exp_pulse(1, TRIG);
        start_signal = 1'b1;
        wait_state(1, 10, c);
        check("start_latency", c, 3);
        tick(20); start_signal = 1'b0; tick(30);
        fg_signal = 1'b1;
        wait_state(2, 10, c);
        check("fg_latency", c, 3);
        tick(20); fg_signal = 1'b0; tick(20);
        start_signal = 1'b1; tick(10); start_signal = 1'b0;
        fg_signal = 1'b1; tick(10); fg_signal = 1'b0;
        wait_state(3, DET_DELAY + 10, c);
        check("det_high_on_entry", int'(detonation_signal), 1);
        tick(10);
        for (int i = 0; i < 10; i++) begin
            wire_signal = 1'b1; tick(hi_len[i]);
            wire_signal = 1'b0; tick(lo_len[i]);
        end
        wire_signal = 1'b1;
        wait_state(4, 60, c);
        check("debounce_latency", c, DEBOUNCE + 3);
        wait_state(5, 5, c);
        check("wire_ok_cycles", c, 1);
        tick(2); detector_ready = 1'b0;
        wait_state(6, 20, c);
        tick(100); detector_ready = 1'b1;
        wait_state(0, 10, c);
        check("ready_return_latency", c, 3);
        wire_signal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fg_signal = 1'b1; tick(20); fg_signal = 1'b0; tick(100);
        end
        check("no_rearm_after_shot", int'(scenario_state), 0);

        // Wire never arrives; fg already high when armed must not count
        exp_state(1, -1); exp_state(2, -1); exp_state(3, DET_DELAY);
        exp_state(7, TIMEOUT + 1); exp_state(0, -1);
        exp_pulse(0, DET_PULSE);
        fg_signal = 1'b1; tick(10);
        start_signal = 1'b1;
        wait_state(1, 10, c);
        tick(30);
        check("fg_high_no_delay", int'(scenario_state), 1);
        fg_signal = 1'b0; tick(10); fg_signal = 1'b1;
        wait_state(2, 10, c);
        fg_signal = 1'b0;
        wait_state(3, DET_DELAY + 10, c);
        wait_state(7, TIMEOUT + 10, c);
        check("timeout_cycles", c, TIMEOUT + 1);
        tick(20);
        check("error_hold_start_high", int'(scenario_state), 7);
        start_signal = 1'b0;
        wait_state(0, 10, c);
        check("error_exit_latency", c, 3);
        tick(30);
        check("no_rearm_without_edge", int'(scenario_state), 0);

        // Start edge with detector not ready is ignored
        detector_ready = 1'b0;
        start_signal = 1'b1; tick(10); start_signal = 1'b0; tick(20);
        check("start_ignored_not_ready", int'(scenario_state), 0);
        detector_ready = 1'b1; tick(10);

        // Detector not ready at wire-valid sends the shot to ERROR
        exp_state(1, -1); exp_state(2, -1); exp_state(3, DET_DELAY);
        exp_state(4, -1); exp_state(7, 1); exp_state(0, -1);
        exp_pulse(0, DET_PULSE);
        start_signal = 1'b1;
        wait_state(1, 10, c);
        start_signal = 1'b0; fg_signal = 1'b1;
        wait_state(2, 10, c);
        fg_signal = 1'b0;
        wait_state(3, DET_DELAY + 10, c);
        tick(70); wire_signal = 1'b1; tick(5); detector_ready = 1'b0;
        wait_state(7, 60, c);
        check("no_trigger_in_error", int'(output_trigger), 0);
        wire_signal = 1'b0; detector_ready = 1'b1;
        wait_state(0, 10, c);

        // Reset mid-pulse clears everything asynchronously
        exp_state(1, -1); exp_state(2, -1); exp_state(3, DET_DELAY);
        start_signal = 1'b1;
        wait_state(1, 10, c);
        start_signal = 1'b0; fg_signal = 1'b1;
        wait_state(2, 10, c);
        fg_signal = 1'b0;
        wait_state(3, DET_DELAY + 10, c);
        tick(10);
        check("det_high_before_reset", int'(detonation_signal), 1);
        reset = 1'b0;
        #1;
        check("async_rst_det", int'(detonation_signal), 0);
        check("async_rst_state", int'(scenario_state), 0);
        check("async_rst_counter", int'(counter_), 0);
        check("async_rst_trig", int'(output_trigger), 0);
        tick(5); reset = 1'b1; tick(5);
        check("idle_after_reset", int'(scenario_state), 0);

        tick(20);
        check("state_queue_empty", st_q.size(), 0);
        check("pulse_queue_empty", pl_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/experiment_fsm.md
Name: experiment_fsm

Overview:
- Sequencer for one synchronized shot: arm on operator start, align to fast-gate pulse, fire detonator, confirm by wire-break sensor, then fire detector trigger.
- Sits between slow asynchronous field inputs (start, fast gate, wire sensor, detector ready) and timing-critical outputs.
- Clocked at 200 MHz; all delays are expressed in clock cycles.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer.
- DET_DELAY_CYC, 360000, cycles from synchronized fast-gate rising edge to detonation (1.8 ms).
- DET_PULSE_CYC, 2000, detonation_signal high width (10 us).
- DEBOUNCE_CYC, 400, cycles wire_signal must stay stable high to count as valid (2 us).
- WIRE_TIMEOUT_CYC, 400000, maximum wait for valid wire after detonation start (2 ms).
- TRIG_PULSE_CYC, 200, output_trigger high width (1 us).
- COUNTER_WIDTH, 32, width of counter_.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- start_signal, in, 1, async start request, level.
- fg_signal, in, 1, async fast-gate pulse train.
- wire_signal, in, 1, async wire-break sensor, bouncy.
- detector_ready, in, 1, async, high = detector can accept trigger.
- detonation_signal, out, 1, detonator fire pulse.
- output_trigger, out, 1, detector trigger pulse.
- scenario_state, out, 3, current state code.
- counter_, out, COUNTER_WIDTH, cycles elapsed in current state.

Behaviour:
- All four inputs pass through SYNC_STAGES synchronizers. Rising-edge detect on the synchronized value adds 1 cycle, giving 3 cycles of input latency.
- While reset is low, the block is in IDLE. All outputs are 0, including counter_ and scenario_state.
- All outputs are registered.
- counter_ clears to 0 on every state change and increments by 1 each cycle otherwise. It saturates at all-ones.

State codes and transitions:
- 0 IDLE: go to 1 on a start_signal rising edge while detector_ready=1. A start edge while detector_ready=0 is ignored.
- 1 ARMED: go to 2 on the next fg_signal rising edge. fg_signal already high when ARMED is entered does not count.
- 2 DELAY: after DET_DELAY_CYC cycles, go to 3. Further fg edges are ignored.
- 3 DETONATE:
  - detonation_signal=1 for exactly DET_PULSE_CYC cycles, then returns to 0.
  - Debounce runs in parallel. A stability counter resets whenever synchronized wire_signal is 0 or toggles.
  - When wire_signal has been stable high for DEBOUNCE_CYC cycles, go to 4.
  - Wire validity is accepted during or after the pulse.
  - If counter_ reaches WIRE_TIMEOUT_CYC first, go to 7.
- 4 WIRE_OK: one cycle. Go to 5 if detector_ready=1, else go to 7.
- 5 TRIGGER: output_trigger=1 for TRIG_PULSE_CYC cycles, then go to 6.
- 6 WAIT_DET: wait for a detector_ready falling edge followed by its return to 1, then go to 0. A low phase already in progress counts.
- 7 ERROR:
  - All pulses forced 0.
  - Stays in ERROR until start_signal=0 and detector_ready=1, then returns to 0.
  - A new start edge is still required to re-arm.
- start_signal edges outside IDLE are ignored.
- Reset asserted mid-sequence aborts immediately. Outputs go to 0 asynchronously, including a partially emitted pulse.
- Never more than one detonation_signal pulse or one output_trigger pulse per armed cycle.

Test Plan:
- Reset low 100 ns, then high; fg 100 us pulses every 10 ms; start pulse 100 us at t=5 ms -> state 1 after sync. At next fg rise +3 cycles: state 2. After 360000 cycles: state 3 with detonation high exactly 2000 cycles.
- Wire high 5 us after detonation, with 10 toggles of 10–100 ns each, then stable high -> exactly one transition to state 4, 400 cycles after the last toggle. output_trigger high for 200 cycles.
- detector_ready low 200 ns after trigger, for 6.4 ms -> stays in state 6 until ready returns, then state 0. No second detonation on later fg edges.
- Wire never asserts -> state 7 at counter_=400000 in state 3. Output_trigger never asserted. After start low and ready high: state 0.
- detector_ready=0 at start edge -> remains in state 0. detector_ready=0 at wire-valid -> state 7, no trigger.
- Reset asserted during state 3 while detonation_signal is high -> detonation_signal, scenario_state and counter_ all 0 immediately.
